// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush controller for the 5-stage MIPS pipeline registers
// (if2id, id2ex, ex2mem, mem2wb). Detects load-use hazards, EX-stage control
// redirects and multi-cycle data-memory waits, and drives per-stage
// enable/flush so each pipeline register holds, advances or bubbles.
// A wait-counter FSM bounds memory stalls and traps on timeout.
//
// Optional build macro: HAZARD_PERF_CNT_EN
//   When defined, adds 32-bit performance counters lu_stall_cnt,
//   redirect_cnt and mem_wait_cnt (cycles in which each action is selected).
//
// Parameters:
//   MEM_WAIT_MAX  max consecutive MEM wait cycles before trapping (>= 2)
//   CNT_W         wait counter width, 2**CNT_W > MEM_WAIT_MAX
//
// Ports:
//   clk            pipeline clock
//   reset          asynchronous active-low reset
//   id_rs, id_rt   source register fields of the ID instruction
//   id_usesrt      ID instruction reads rt
//   ex_memtoreg    EX instruction is a load
//   ex_regwriteen  EX instruction writes the register file
//   ex_writereg    EX destination register
//   ex_redirect    EX resolved a taken branch / jump
//   mem_req        MEM stage holds a load/store
//   mem_ready      data memory completes the access this cycle
//   pc_en, if2id_en, id2ex_en, ex2mem_en     stage load enables
//   if2id_flush, id2ex_flush, mem2wb_flush   stage bubble inserts
//   state          FSM state: 00 RUN, 01 MEM_WAIT, 11 TRAP
//   mem_timeout    sticky trap flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; hazards and redirects steer the pipeline
// MEM_WAIT | data memory access outstanding, counting wait cycles
// TRAP     | memory wait exceeded MEM_WAIT_MAX, pipeline frozen
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MEM_WAIT_MAX = 16,
    parameter int CNT_W        = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_usesrt,
    input  logic        ex_memtoreg,
    input  logic        ex_regwriteen,
    input  logic [4:0]  ex_writereg,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if2id_en,
    output logic        if2id_flush,
    output logic        id2ex_en,
    output logic        id2ex_flush,
    output logic        ex2mem_en,
    output logic        mem2wb_flush,
    output logic [1:0]  state,
    output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] lu_stall_cnt,
    output logic [31:0] redirect_cnt,
    output logic [31:0] mem_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_TRAP     = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt;

    logic lu;
    logic in_trap;
    logic mem_stall;
    logic act_redirect;
    logic act_lu;

    assign state = state_q;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign lu = ex_memtoreg & ex_regwriteen & (ex_writereg != 5'd0) &
                ((ex_writereg == id_rs) | (id_usesrt & (ex_writereg == id_rt)));

    assign in_trap      = (state_q == ST_TRAP);
    assign mem_stall    = ~in_trap & mem_req & ~mem_ready;
    // A redirect or load-use seen during a memory wait is dropped; the EX/ID
    // contents are held, so it is seen again once the wait ends.
    assign act_redirect = ~in_trap & ~mem_stall & ex_redirect;
    assign act_lu       = ~in_trap & ~mem_stall & ~ex_redirect & lu;

    always_comb begin
        pc_en        = 1'b1;
        if2id_en     = 1'b1;
        if2id_flush  = 1'b0;
        id2ex_en     = 1'b1;
        id2ex_flush  = 1'b0;
        ex2mem_en    = 1'b1;
        mem2wb_flush = 1'b0;
        if (reset) begin
            if (in_trap || mem_stall) begin
                pc_en        = 1'b0;
                if2id_en     = 1'b0;
                id2ex_en     = 1'b0;
                ex2mem_en    = 1'b0;
                mem2wb_flush = 1'b1;
            end else if (act_redirect) begin
                if2id_flush = 1'b1;
                id2ex_flush = 1'b1;
            end else if (act_lu) begin
                // The load moves on to MEM, so the hazard clears next cycle.
                pc_en       = 1'b0;
                if2id_en    = 1'b0;
                id2ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state_q  <= ST_MEM_WAIT;
                        wait_cnt <= CNT_ONE;
                    end
                end
                ST_MEM_WAIT: begin
                    // Dropping mem_req is treated the same as completion.
                    if (!mem_req || mem_ready) begin
                        state_q  <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                        if (wait_cnt == CNT_LAST) begin
                            state_q     <= ST_TRAP;
                            mem_timeout <= 1'b1;
                        end
                    end
                end
                ST_TRAP: begin
                    state_q <= ST_TRAP;
                end
                default: begin
                    state_q  <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // The act_* terms are already zero in TRAP, which freezes the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lu_stall_cnt <= '0;
            redirect_cnt <= '0;
            mem_wait_cnt <= '0;
        end else begin
            if (act_lu)       lu_stall_cnt <= lu_stall_cnt + 32'd1;
            if (act_redirect) redirect_cnt <= redirect_cnt + 32'd1;
            if (mem_stall)    mem_wait_cnt <= mem_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline registers (if2id, id2ex, ex2mem, mem2wb).
- Detects load-use hazards, EX-stage control redirects (taken branch, jump, jump-to-register) and multi-cycle data-memory waits.
- Drives per-stage enable/flush so that each pipeline register holds, advances or bubbles.
- A wait-counter FSM bounds memory stalls and traps on timeout.

Parameters:
MEM_WAIT_MAX, 16, maximum consecutive cycles the MEM stage may wait for mem_ready before trapping (>=2).
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MEM_WAIT_MAX.

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_usesrt  in  1  ID instruction reads rt as a source
ex_memtoreg  in  1  EX instruction is a load
ex_regwriteen  in  1  EX instruction writes the register file
ex_writereg  in  5  EX destination register
ex_redirect  in  1  EX resolved a taken branch or jump
mem_req  in  1  MEM stage holds a load/store
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC register update enable
if2id_en  out  1  if2id load enable
if2id_flush  out  1  if2id clear to NOP
id2ex_en  out  1  id2ex load enable
id2ex_flush  out  1  id2ex clear to bubble (all control bits 0)
ex2mem_en  out  1  ex2mem load enable
mem2wb_flush  out  1  insert bubble into mem2wb
state  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 11 TRAP
mem_timeout  out  1  sticky trap flag

Behaviour:
- Reset (reset=0, async): state=RUN, wait counter=0, mem_timeout=0.
- Outputs during reset: all *_en=1, all *_flush=0.
- Stall/flush outputs are combinational from current inputs and the registered state. Zero-cycle latency: they act at the next clk edge.
- Load-use hazard (lu) = ex_memtoreg & ex_regwriteen & ex_writereg!=0 & (ex_writereg==id_rs | (id_usesrt & ex_writereg==id_rt)).
- Priority, highest first: TRAP > mem wait > redirect > lu > normal.
- TRAP: all *_en=0, mem2wb_flush=1, other flushes 0. Held until reset.
- Mem wait (mem_req & !mem_ready, state RUN or MEM_WAIT): pc_en=if2id_en=id2ex_en=ex2mem_en=0, mem2wb_flush=1, if2id_flush=id2ex_flush=0.
  - A redirect or lu present at the same time is ignored this cycle. It is re-evaluated after the wait ends, because the EX/ID contents are held.
- Redirect: all enables 1, if2id_flush=1, id2ex_flush=1. Squashes the 2 younger instructions.
  - Redirect wins over lu because the ID instruction is squashed.
- lu: pc_en=0, if2id_en=0, id2ex_flush=1, ex2mem_en=1. One-cycle bubble.
  - The hazard clears itself the next cycle because the load advances to MEM.
- Normal: all enables 1, all flushes 0.
- FSM transitions:
  - RUN -> MEM_WAIT when mem_req & !mem_ready; counter <= 1.
  - MEM_WAIT -> RUN when mem_ready; counter <= 0.
  - MEM_WAIT, still waiting: counter <= counter+1. If counter == MEM_WAIT_MAX-1 the next state is TRAP and mem_timeout <= 1.
  - TRAP -> TRAP.
  - mem_req dropping while in MEM_WAIT counts as completion -> RUN.
- mem_req & mem_ready in RUN: single-cycle access, no stall, state stays RUN.
- Reset asserted mid-wait or in TRAP: immediate return to RUN, counter 0, mem_timeout 0.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: adds 32-bit outputs lu_stall_cnt, redirect_cnt and mem_wait_cnt.
  - Each counts cycles in which its condition is the selected (highest-priority) action.
  - Counters wrap modulo 2^32, clear on reset, and freeze in TRAP.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use: ex_memtoreg=1, ex_regwriteen=1, ex_writereg=8, id_rs=8 -> one cycle with pc_en=0, if2id_en=0, id2ex_flush=1. Next cycle (ex_memtoreg=0) all enables 1.
- No false hazard: ex_writereg=0, id_rs=0, load in EX -> no stall. Also id_usesrt=0, id_rt=ex_writereg=9 -> no stall.
- Redirect with simultaneous lu: ex_redirect=1 and lu=1 -> if2id_flush=1, id2ex_flush=1, pc_en=1.
- Mem wait of 3 cycles: mem_req=1, mem_ready=0 for 3 cycles then 1 -> state 01 for 3 cycles, stage enables 0, mem2wb_flush=1; then state 00, counter 0.
- Timeout, MEM_WAIT_MAX=4: mem_ready held 0 -> state=11 and mem_timeout=1 after the 4th wait cycle, all enables stay 0. Asserting reset=0 mid-TRAP -> state 00 immediately (async).
- With HAZARD_PERF_CNT_EN defined: one lu, two redirects and a 3-cycle wait -> lu_stall_cnt=1, redirect_cnt=2, mem_wait_cnt=3.
